scpu_debug_ctrl: RTL and testbench
==================================

Name: scpu_debug_ctrl

Overview:
- Run-control sequencer for the single-cycle CPU `scpu`. Drives the core's clock-enable, so the core retires one instruction per cycle while `cpu_en`=1.
- Provides run/halt/single-step commands, PC breakpoints, and stop-on-`hlt`.
- Performs a register-file dump over a valid/ready stream, both on command and on the core's `debugDump` pulse.
- Sits between a host/debug-bus command port and the core's enable, PC, status and register-read port.

Parameters:
NREGS, 32, number of architectural registers walked by a dump
REG_AW, 5, register address width ($clog2(NREGS))
NUM_BP, 2, number of PC breakpoint slots
BP_AW, 1, breakpoint slot index width ($clog2(NUM_BP), min 1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready
cmd_op  in  3  0 NOP, 1 RUN, 2 HALT, 3 STEP, 4 DUMP, 5 SETBP, 6 CLRBP, 7 NOP
cmd_slot  in  BP_AW  breakpoint slot for SETBP/CLRBP
cmd_arg  in  32  breakpoint PC for SETBP
cpu_en  out  1  core clock-enable (combinational)
cpu_pc  in  32  PC of the instruction executing this cycle
cpu_halt  in  1  core haltTriggered, level, sticky until reset
cpu_dump  in  1  core debugDump, meaningful only when cpu_en=1
reg_raddr  out  REG_AW  register-file read address
reg_rdata  in  32  combinational read data for reg_raddr
dump_valid  out  1  dump word valid
dump_ready  in  1  dump sink ready
dump_data  out  32  register value (equals reg_rdata)
dump_last  out  1  marks the last word of a dump
status  out  2  0 HALTED, 1 RUN, 2 STEP, 3 DUMP
stop_cause  out  2  0 RESET, 1 CMD, 2 BP, 3 HLT

Behaviour:
- Reset (async, any state) produces:
  - state HALTED, stop_cause=RESET, all breakpoint slots invalid, dump index 0, return-state HALTED, skip_bp=0.
  - Outputs: cpu_en=0, dump_valid=0, dump_last=0, reg_raddr=0, cmd_ready=1.
- cmd_ready = (state==HALTED || state==RUN). The command port is stalled in STEP and DUMP.
- bp_hit = OR over valid slots of (bp_pc[i]==cpu_pc), masked by skip_bp.
- cpu_en = (RUN && !bp_hit && !cpu_halt) || (STEP && !cpu_halt). cpu_en is never 1 in HALTED or DUMP.

HALTED state:
- RUN: to RUN, sets skip_bp=1. RUN is ignored if cpu_halt=1.
- STEP: to STEP. STEP is ignored if cpu_halt=1.
- DUMP: to DUMP with return-state HALTED.
- SETBP: writes bp_pc[cmd_slot]=cmd_arg, valid=1.
- CLRBP: clears valid of slot cmd_slot.
- HALT and NOP: no effect.

RUN state:
- skip_bp clears after the first RUN cycle, so the core can resume from a breakpoint PC.
- Priority within one cycle, highest first:
  1. cpu_halt=1: to HALTED, stop_cause=HLT.
  2. bp_hit: to HALTED, stop_cause=BP. The instruction at the breakpoint PC is not executed.
  3. HALT command accepted: to HALTED, stop_cause=CMD. The current instruction still executes (cpu_en=1 this cycle).
  4. cpu_dump with cpu_en=1: to DUMP, return-state RUN. The dump instruction retires this cycle.
  5. DUMP command accepted: to DUMP, return-state RUN.
- SETBP/CLRBP are applied and take effect the next cycle.
- RUN/STEP/NOP commands are accepted and ignored.

STEP state:
- Lasts exactly 1 cycle with cpu_en=1 (exactly one instruction retires). Breakpoints are ignored.
- Next state is HALTED with stop_cause=CMD.
- If cpu_dump=1 in that cycle, next state is DUMP with return-state HALTED (stop_cause=CMD).
- If cpu_halt=1 in that cycle, next state is HALTED with stop_cause=HLT.

DUMP state:
- Signal mapping: reg_raddr=idx, dump_valid=1, dump_data=reg_rdata, dump_last=(idx==NREGS-1).
- idx increments on handshake. On the last handshake: idx returns to 0 and the state goes to return-state.
- The core is frozen throughout, so dumped values are stable.
- dump_valid stays high and dump_data stays stable while dump_ready=0 (no drop, no advance).
- Re-entering RUN from DUMP sets skip_bp=1.

Decomposition:
- Package scpu_dbg_pkg holds:
  - typedef enum dbg_state_e {HALTED, RUN, STEP, DUMP};
  - typedef enum dbg_cmd_e for the 3-bit opcodes;
  - typedef enum stop_cause_e {RESET, CMD, BP, HLT}.
- Sub-module scpu_bp_unit: NUM_BP slot registers with set/clear and a combinational hit compare. The remaining FSM, counter and stream logic live in scpu_debug_ctrl.

Test Plan:
- Reset release -> status=0, stop_cause=0, cpu_en=0. SETBP slot0=0x10; RUN from PC 0 -> cpu_en=1 for PCs 0x0..0xC. At PC 0x10: cpu_en=0, status=0, stop_cause=2.
- At halt on 0x10 issue RUN -> PC 0x10 executes (skip_bp), run continues. CLRBP slot0 -> no further stop at 0x10.
- STEP from HALTED -> exactly one cpu_en cycle, cmd_ready=0 for that cycle, then status=0, stop_cause=1. Repeat STEP 3 times -> PC advanced by 3 instructions.
- DUMP with dump_ready toggling 1/0 -> 32 handshakes with data = regs r0..r31 in order, dump_last only on r31, cpu_en=0 throughout, then back to HALTED.
- RUN with cpu_dump pulse at an instruction -> next cycle status=3; after 32 words, status=1 and execution resumes. cpu_halt rising in RUN -> cpu_en=0 in the same cycle, stop_cause=3; subsequent RUN/STEP ignored.
- Assert reset mid-DUMP at idx=5 -> immediately status=0, dump_valid=0, breakpoints cleared; a new DUMP starts at r0.

Source files
------------

// File: rtl/scpu_dbg_pkg.sv
// Shared types for the scpu run-control sequencer: FSM states, host opcodes
// and the reason the core last stopped.
package scpu_dbg_pkg;

  typedef enum logic [1:0] {
    ST_HALTED = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2,
    ST_DUMP   = 2'd3
  } dbg_state_e;

  typedef enum logic [2:0] {
    CMD_NOP   = 3'd0,
    CMD_RUN   = 3'd1,
    CMD_HALT  = 3'd2,
    CMD_STEP  = 3'd3,
    CMD_DUMP  = 3'd4,
    CMD_SETBP = 3'd5,
    CMD_CLRBP = 3'd6,
    CMD_NOP7  = 3'd7
  } dbg_cmd_e;

  typedef enum logic [1:0] {
    CAUSE_RESET = 2'd0,
    CAUSE_CMD   = 2'd1,
    CAUSE_BP    = 2'd2,
    CAUSE_HLT   = 2'd3
  } stop_cause_e;

endpackage

// File: rtl/scpu_debug_ctrl_bp.sv
// PC breakpoint slots: per-slot address and valid bit with set/clear, plus a
// combinational match against the executing PC (suppressed while skip is set).
module scpu_bp_unit #(
  parameter int unsigned NUM_BP = 2,
  parameter int unsigned BP_AW  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set_en,
  input  logic             clr_en,
  input  logic [BP_AW-1:0] slot,
  input  logic [31:0]      arg,
  input  logic [31:0]      pc,
  input  logic             skip,
  output logic             hit
);

  logic [NUM_BP-1:0] bp_valid;
  logic [31:0]       bp_pc [NUM_BP];
  logic [NUM_BP-1:0] match;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bp_valid <= '0;
    end else if (set_en) begin
      bp_valid[slot] <= 1'b1;
    end else if (clr_en) begin
      bp_valid[slot] <= 1'b0;
    end
  end

  // Addresses are only meaningful once their valid bit is set, so no reset.
  always_ff @(posedge clk) begin
    if (set_en) begin
      bp_pc[slot] <= arg;
    end
  end

  for (genvar g = 0; g < NUM_BP; g++) begin : g_cmp
    assign match[g] = bp_valid[g] && (bp_pc[g] == pc);
  end

  assign hit = (|match) && !skip;

endmodule

// File: rtl/scpu_debug_ctrl.sv
// Run-control sequencer for scpu: gates the core clock-enable for run/step,
// stops on breakpoints or hlt, and streams the register file out on dump.
module scpu_debug_ctrl
  import scpu_dbg_pkg::*;
#(
  parameter int unsigned NREGS  = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned NUM_BP = 2,
  parameter int unsigned BP_AW  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [BP_AW-1:0]  cmd_slot,
  input  logic [31:0]       cmd_arg,
  output logic              cpu_en,
  input  logic [31:0]       cpu_pc,
  input  logic              cpu_halt,
  input  logic              cpu_dump,
  output logic [REG_AW-1:0] reg_raddr,
  input  logic [31:0]       reg_rdata,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [31:0]       dump_data,
  output logic              dump_last,
  output logic [1:0]        status,
  output logic [1:0]        stop_cause
);

  dbg_state_e  state, state_n;
  dbg_state_e  ret_state, ret_state_n;
  stop_cause_e cause, cause_n;
  logic        skip_bp, skip_bp_n;
  logic [REG_AW-1:0] idx, idx_n;

  dbg_cmd_e op;
  logic     cmd_fire;
  logic     bp_hit;
  logic     is_last;

  assign op        = dbg_cmd_e'(cmd_op);
  assign cmd_ready = (state == ST_HALTED) || (state == ST_RUN);
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign is_last   = (idx == REG_AW'(NREGS - 1));

  scpu_bp_unit #(
    .NUM_BP (NUM_BP),
    .BP_AW  (BP_AW)
  ) u_bp (
    .clk    (clk),
    .reset  (reset),
    .set_en (cmd_fire && (op == CMD_SETBP)),
    .clr_en (cmd_fire && (op == CMD_CLRBP)),
    .slot   (cmd_slot),
    .arg    (cmd_arg),
    .pc     (cpu_pc),
    .skip   (skip_bp),
    .hit    (bp_hit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_HALTED;
      ret_state <= ST_HALTED;
      cause     <= CAUSE_RESET;
      skip_bp   <= 1'b0;
      idx       <= '0;
    end else begin
      state     <= state_n;
      ret_state <= ret_state_n;
      cause     <= cause_n;
      skip_bp   <= skip_bp_n;
      idx       <= idx_n;
    end
  end

  always_comb begin
    state_n     = state;
    ret_state_n = ret_state;
    cause_n     = cause;
    skip_bp_n   = skip_bp;
    idx_n       = idx;
    cpu_en      = 1'b0;
    dump_valid  = 1'b0;
    dump_last   = 1'b0;

    unique case (state)
      ST_HALTED: begin
        if (cmd_fire) begin
          case (op)
            CMD_RUN: begin
              if (!cpu_halt) begin
                state_n   = ST_RUN;
                skip_bp_n = 1'b1;
              end
            end
            CMD_STEP: begin
              if (!cpu_halt) state_n = ST_STEP;
            end
            CMD_DUMP: begin
              state_n     = ST_DUMP;
              ret_state_n = ST_HALTED;
            end
            default: ;
          endcase
        end
      end

      ST_RUN: begin
        cpu_en    = !bp_hit && !cpu_halt;
        // Skip only covers the first cycle so a run can resume off a breakpoint PC.
        skip_bp_n = 1'b0;
        if (cpu_halt) begin
          state_n = ST_HALTED;
          cause_n = CAUSE_HLT;
        end else if (bp_hit) begin
          state_n = ST_HALTED;
          cause_n = CAUSE_BP;
        end else if (cmd_fire && (op == CMD_HALT)) begin
          state_n = ST_HALTED;
          cause_n = CAUSE_CMD;
        end else if (cpu_dump || (cmd_fire && (op == CMD_DUMP))) begin
          state_n     = ST_DUMP;
          ret_state_n = ST_RUN;
        end
      end

      ST_STEP: begin
        cpu_en = !cpu_halt;
        if (cpu_halt) begin
          state_n = ST_HALTED;
          cause_n = CAUSE_HLT;
        end else if (cpu_dump) begin
          state_n     = ST_DUMP;
          ret_state_n = ST_HALTED;
          cause_n     = CAUSE_CMD;
        end else begin
          state_n = ST_HALTED;
          cause_n = CAUSE_CMD;
        end
      end

      ST_DUMP: begin
        dump_valid = 1'b1;
        dump_last  = is_last;
        if (dump_ready) begin
          if (is_last) begin
            idx_n   = '0;
            state_n = ret_state;
            if (ret_state == ST_RUN) skip_bp_n = 1'b1;
          end else begin
            idx_n = idx + REG_AW'(1);
          end
        end
      end

      default: ;
    endcase
  end

  assign reg_raddr  = idx;
  assign dump_data  = reg_rdata;
  assign status     = 2'(state);
  assign stop_cause = 2'(cause);

endmodule

// File: tb/tb_scpu_debug_ctrl.sv
// Bench for scpu_debug_ctrl: a looping core model plus a rule-level reference
// model checked every cycle, directed scenarios, then randomized traffic.
module tb_scpu_debug_ctrl;

  localparam int NREGS  = 32;
  localparam int REG_AW = 5;
  localparam int NUM_BP = 2;
  localparam int BP_AW  = 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              cmd_valid, cmd_ready;
  logic [2:0]        cmd_op;
  logic [BP_AW-1:0]  cmd_slot;
  logic [31:0]       cmd_arg;
  logic              cpu_en;
  logic [31:0]       cpu_pc;
  logic              cpu_halt, cpu_dump;
  logic [REG_AW-1:0] reg_raddr;
  logic [31:0]       reg_rdata;
  logic              dump_valid, dump_ready, dump_last;
  logic [31:0]       dump_data;
  logic [1:0]        status, stop_cause;

  logic [31:0] regs [NREGS];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  scpu_debug_ctrl #(
    .NREGS  (NREGS),
    .REG_AW (REG_AW),
    .NUM_BP (NUM_BP),
    .BP_AW  (BP_AW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_slot   (cmd_slot),
    .cmd_arg    (cmd_arg),
    .cpu_en     (cpu_en),
    .cpu_pc     (cpu_pc),
    .cpu_halt   (cpu_halt),
    .cpu_dump   (cpu_dump),
    .reg_raddr  (reg_raddr),
    .reg_rdata  (reg_rdata),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_data  (dump_data),
    .dump_last  (dump_last),
    .status     (status),
    .stop_cause (stop_cause)
  );

  // Core stand-in: a 32-instruction loop, frozen whenever cpu_en is low.
  assign reg_rdata = regs[reg_raddr];
  always @(posedge clk or posedge reset) begin
    if (reset) cpu_pc <= 32'h0;
    else if (cpu_en) cpu_pc <= (cpu_pc + 32'd4) & 32'h7F;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model. mode mirrors the architectural status: 0 halted, 1 run, 2 step, 3 dump.
  int          m_mode, m_cause, m_idx, m_ret;
  bit          m_skip;
  bit          m_bpv [NUM_BP];
  logic [31:0] m_bpc [NUM_BP];

  always @(negedge clk) begin
    bit hit, en, rdy, fire;
    int raddr;
    if (reset) begin
      m_mode = 0; m_cause = 0; m_idx = 0; m_ret = 0; m_skip = 0;
      for (int i = 0; i < NUM_BP; i++) m_bpv[i] = 0;
      check("rst_cpu_en", cpu_en, 0);
      check("rst_dump_valid", dump_valid, 0);
      check("rst_dump_last", dump_last, 0);
      check("rst_reg_raddr", reg_raddr, 0);
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_status", status, 0);
      check("rst_stop_cause", stop_cause, 0);
    end else begin
      hit = 0;
      if (!m_skip)
        for (int i = 0; i < NUM_BP; i++)
          if (m_bpv[i] && m_bpc[i] == cpu_pc) hit = 1;
      en    = (m_mode == 1 && !hit && !cpu_halt) || (m_mode == 2 && !cpu_halt);
      rdy   = (m_mode == 0 || m_mode == 1);
      fire  = rdy && cmd_valid;
      raddr = (m_mode == 3) ? m_idx : 0;

      check("cmp_cpu_en", cpu_en, en);
      check("cmp_cmd_ready", cmd_ready, rdy);
      check("cmp_status", status, m_mode);
      check("cmp_stop_cause", stop_cause, m_cause);
      check("cmp_dump_valid", dump_valid, m_mode == 3);
      check("cmp_dump_last", dump_last, m_mode == 3 && m_idx == NREGS - 1);
      check("cmp_reg_raddr", reg_raddr, raddr);
      if (m_mode == 3) check("cmp_dump_data", dump_data, regs[raddr]);

      if (fire && cmd_op == 3'd5) begin m_bpv[cmd_slot] = 1; m_bpc[cmd_slot] = cmd_arg; end
      if (fire && cmd_op == 3'd6) m_bpv[cmd_slot] = 0;

      case (m_mode)
        0: if (fire) begin
             if (cmd_op == 3'd1 && !cpu_halt) begin m_mode = 1; m_skip = 1; end
             else if (cmd_op == 3'd3 && !cpu_halt) m_mode = 2;
             else if (cmd_op == 3'd4) begin m_mode = 3; m_ret = 0; end
           end
        1: begin
             m_skip = 0;
             if (cpu_halt) begin m_mode = 0; m_cause = 3; end
             else if (hit) begin m_mode = 0; m_cause = 2; end
             else if (fire && cmd_op == 3'd2) begin m_mode = 0; m_cause = 1; end
             else if (cpu_dump) begin m_mode = 3; m_ret = 1; end
             else if (fire && cmd_op == 3'd4) begin m_mode = 3; m_ret = 1; end
           end
        2: begin
             m_mode  = 0;
             m_cause = cpu_halt ? 3 : 1;
             if (!cpu_halt && cpu_dump) begin m_mode = 3; m_ret = 0; end
           end
        default: if (dump_ready) begin
             if (m_idx == NREGS - 1) begin
               m_idx = 0; m_mode = m_ret;
               if (m_ret == 1) m_skip = 1;
             end else m_idx++;
           end
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int op, input int slot = 0, input logic [31:0] arg = 32'h0);
    cmd_valid = 1'b1;
    cmd_op    = 3'(op);
    cmd_slot  = BP_AW'(slot);
    cmd_arg   = arg;
    tick();
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
  endtask

  initial begin
    int cnt, k;
    logic [31:0] pc0;
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_slot = '0; cmd_arg = '0;
    cpu_halt = 1'b0; cpu_dump = 1'b0; dump_ready = 1'b1;
    for (int i = 0; i < NREGS; i++) regs[i] = $urandom;
    tick(); tick();
    reset = 1'b0;
    tick();
    check("init_status", status, 0);
    check("init_stop_cause", stop_cause, 0);
    check("init_cpu_en", cpu_en, 0);

    // Breakpoint at 0x10: four instructions run, then stop with BP.
    issue(5, 0, 32'h10);
    issue(1);
    cnt = 0;
    for (int c = 0; c < 50 && status != 2'd0; c++) begin
      if (cpu_en) cnt++;
      tick();
    end
    check("bp_en_cycles", cnt, 4);
    check("bp_pc", cpu_pc, 32'h10);
    check("bp_cause", stop_cause, 2);
    check("bp_cpu_en", cpu_en, 0);

    // Resume from the breakpoint PC, then clear it and run past it again.
    issue(1);
    check("resume_en", cpu_en, 1);
    tick();
    check("resume_pc", cpu_pc, 32'h14);
    issue(6, 0);
    repeat (40) tick();
    check("clrbp_still_run", status, 1);
    issue(2);
    check("halt_status", status, 0);
    check("halt_cause", stop_cause, 1);

    // Three single steps.
    pc0 = cpu_pc;
    for (int s = 0; s < 3; s++) begin
      issue(3);
      check("step_en", cpu_en, 1);
      check("step_ready", cmd_ready, 0);
      tick();
      check("step_status", status, 0);
      check("step_cause", stop_cause, 1);
    end
    check("step_pc", cpu_pc, (pc0 + 32'd12) & 32'h7F);

    // Dump with a toggling sink.
    issue(4);
    k = 0;
    for (int c = 0; c < 200 && k < NREGS; c++) begin
      dump_ready = (c % 2 == 0);
      #1;
      check("dump_cpu_en", cpu_en, 0);
      if (dump_valid && dump_ready) begin
        check("dump_word", dump_data, regs[k]);
        check("dump_last", dump_last, k == NREGS - 1);
        k++;
      end
      tick();
    end
    dump_ready = 1'b1;
    check("dump_count", k, NREGS);
    check("dump_return", status, 0);

    // Core-triggered dump while running, then resume.
    issue(1);
    tick(); tick();
    cpu_dump = 1'b1;
    #1;
    check("cdump_en", cpu_en, 1);
    pc0 = cpu_pc;
    tick();
    cpu_dump = 1'b0;
    check("cdump_status", status, 3);
    check("cdump_retired", cpu_pc, (pc0 + 32'd4) & 32'h7F);
    for (int c = 0; c < 100 && status == 2'd3; c++) tick();
    check("cdump_back_run", status, 1);
    check("cdump_resume_en", cpu_en, 1);

    // hlt stops the core in the same cycle and blocks RUN/STEP.
    cpu_halt = 1'b1;
    #1;
    check("hlt_en_same_cycle", cpu_en, 0);
    tick();
    check("hlt_status", status, 0);
    check("hlt_cause", stop_cause, 3);
    issue(1);
    check("hlt_run_ignored", status, 0);
    issue(3);
    check("hlt_step_ignored", status, 0);

    // Reset in the middle of a dump.
    reset = 1'b1; cpu_halt = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    issue(5, 1, 32'h8);
    issue(4);
    repeat (5) tick();
    check("middump_idx", reg_raddr, 5);
    reset = 1'b1;
    #1;
    check("middump_rst_status", status, 0);
    check("middump_rst_valid", dump_valid, 0);
    tick();
    reset = 1'b0;
    tick();
    issue(4);
    check("redump_idx", reg_raddr, 0);
    check("redump_data", dump_data, regs[0]);
    for (int c = 0; c < 100 && status == 2'd3; c++) tick();
    issue(1);
    repeat (6) tick();
    check("bp_cleared_status", status, 1);
    check("bp_cleared_pc", cpu_pc, 32'h18);
    issue(2);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(499) == 0) begin
        reset = 1'b1; cpu_halt = 1'b0; cmd_valid = 1'b0; cpu_dump = 1'b0;
        tick();
        reset = 1'b0;
      end else begin
        if ($urandom_range(399) == 0) cpu_halt = 1'b1;
        cmd_valid  = ($urandom_range(2) == 0);
        cmd_op     = 3'($urandom_range(7));
        cmd_slot   = BP_AW'($urandom_range(NUM_BP - 1));
        cmd_arg    = 32'($urandom_range(31) * 4);
        cpu_dump   = ($urandom_range(15) == 0);
        dump_ready = ($urandom_range(1) == 0);
        tick();
      end
    end
    cmd_valid = 1'b0; cpu_dump = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
